// File: rtl/serial_sub_pkg.sv
// Shared types and the borrow equation for the bit-serial subtractor.
// The borrow rule lives here so that the cell and any future users agree on it.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic borrow_next(input logic a, input logic b, input logic br);
    return (~a & b) | (~a & br) | (b & br);
  endfunction

endpackage

// File: rtl/serial_sub_full_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - br, br_out = borrow out.
// Purely combinational, no latency, no flow control.
module full_sub_bit
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br;
  assign br_out = borrow_next(a, b, br);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, LSB first; result valid N_BITS clocks after accept, held until out_ready.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic              ovf,
`endif
  output logic              bout
);

  localparam int            CW   = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  state_e            state_q;
  logic [N_BITS-1:0] a_sr_q, b_sr_q, diff_sr_q;
  logic [N_BITS-1:0] diff_d;
  logic [CW-1:0]     count_q;
  logic              br_q, br_d, d_bit;
  logic              in_ready_q, out_valid_q, bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic              ovf_q;
`endif

  full_sub_bit u_cell (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .br     (br_q),
    .d      (d_bit),
    .br_out (br_d)
  );

  // New bit enters at the MSB so that after N_BITS shifts bit 0 sits at the LSB.
  assign diff_d = (diff_sr_q >> 1) | (N_BITS'(d_bit) << (N_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      diff_sr_q   <= '0;
      br_q        <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bout_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q     <= a;
            b_sr_q     <= b;
            br_q       <= bin;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          a_sr_q    <= a_sr_q >> 1;
          b_sr_q    <= b_sr_q >> 1;
          br_q      <= br_d;
          diff_sr_q <= diff_d;
          count_q   <= count_q + CW'(1);
          if (count_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            bout_q      <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // br_q still holds the borrow into the sign bit here.
            ovf_q       <= br_q ^ br_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_sr_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed literal cases plus a randomized sweep, all checked every cycle against an arithmetic model.
module tb_serial_sub;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_sub #(.N_BITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: {ovf, bout, diff}.
  function automatic logic [N+1:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic bi);
    int r, sx, sy, s;
    logic [31:0] rv;
    logic        o;
    r  = int'(x) - int'(y) - int'(bi);
    rv = r;
    sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
    sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
    s  = sx - sy - int'(bi);
    o  = (s < -(1 << (N-1))) || (s > (1 << (N-1)) - 1);
    return {o, (r < 0), rv[N-1:0]};
  endfunction

  // Transaction-level model: waiting = operands accepted and result not yet taken.
  logic         m_wait;
  int           m_cyc;
  int           m_ops;
  logic [N+1:0] m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0;
      m_cyc  <= 0;
    end else if (!m_wait) begin
      if (in_valid) begin
        m_wait <= 1'b1;
        m_cyc  <= 0;
        m_exp  <= ref_sub(a, b, bin);
        m_ops  <= m_ops + 1;
      end
    end else if (m_cyc == N) begin
      if (out_ready) m_wait <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  initial m_ops = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, !m_wait);
      chk("out_valid", out_valid, m_wait && m_cyc == N);
      if (m_wait && m_cyc == N) begin
        chk("diff", diff, m_exp[N-1:0]);
        chk("bout", bout, m_exp[N]);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, m_exp[N+1]);
`endif
      end
    end
  end

  logic [N-1:0] r_diff;
  logic         r_bout;
  logic         r_ovf;

  // One operation: optionally scramble inputs while busy, hold the result for 'hold' cycles.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                        input int hold, input logic noise);
    bit seen = 0;
    a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4 * N + 20; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
      if (noise) begin
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom); in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!seen) begin
      chk("result_timeout", 0, 1);
      return;
    end
    r_diff = diff; r_bout = bout;
`ifdef SERIAL_SUB_OVF_EN
    r_ovf = ovf;
`else
    r_ovf = 1'b0;
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_diff", diff, r_diff);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", in_ready, 1);
    chk("valid_dropped", out_valid, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd5, 4'd3, 1'b0, 0, 1'b0);
    chk("lit_5m3_diff", r_diff, 4'd2);
    chk("lit_5m3_bout", r_bout, 0);

    run_op(4'd3, 4'd5, 1'b0, 0, 1'b0);
    chk("lit_3m5_diff", r_diff, 4'hE);
    chk("lit_3m5_bout", r_bout, 1);

    run_op(4'd0, 4'd0, 1'b1, 0, 1'b0);
    chk("lit_wrap_diff", r_diff, 4'hF);
    chk("lit_wrap_bout", r_bout, 1);

    run_op(4'd9, 4'd4, 1'b0, 6, 1'b0);
    chk("lit_bp_diff", r_diff, 4'd5);
    chk("lit_bp_bout", r_bout, 0);

    // Abort in BUSY with count==2.
    a = 4'd12; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_diff", diff, 0);
    run_op(4'd7, 4'd7, 1'b0, 0, 1'b0);
    chk("lit_7m7_diff", r_diff, 4'd0);
    chk("lit_7m7_bout", r_bout, 0);

    run_op(4'd6, 4'd2, 1'b1, 1, 1'b1);
    chk("lit_noise_diff", r_diff, 4'd3);
    chk("lit_noise_bout", r_bout, 0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'd8, 4'd1, 1'b0, 0, 1'b0);
    chk("lit_ovf_diff", r_diff, 4'd7);
    chk("lit_ovf_set", r_ovf, 1);
    run_op(4'd2, 4'd1, 1'b0, 0, 1'b0);
    chk("lit_noovf_diff", r_diff, 4'd1);
    chk("lit_noovf_clr", r_ovf, 0);
`endif

    // Random sweep: random operands, request gaps and output backpressure.
    begin
      int start_ops;
      int cyc;
      start_ops = m_ops;
      cyc = 0;
      while (m_ops - start_ops < 1000 && cyc < 40000) begin
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        @(posedge clk); #1;
        cyc++;
      end
      chk("sweep_op_count", (m_ops - start_ops >= 1000), 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (N + 4) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
